// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit for the 5-stage RISC-V pipeline.
// Turns the EX/MEM load/store into one request/grant/response transaction on
// the data-memory bus, returns extended load data and stalls upstream stages
// while the transaction is in flight. A watchdog aborts transactions the bus
// never answers.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_Read_M,
    input  logic        Mem_Write_M,
    input  logic [2:0]  Funct3_M,
    input  logic [31:0] Alu_Result_M,
    input  logic [31:0] Write_Data_M,
    output logic [31:0] Read_DataM,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        Bus_Err_M,
    output logic        Bus_Req,
    output logic        Bus_We,
    output logic [31:0] Bus_Addr,
    output logic [31:0] Bus_WData,
    output logic [3:0]  Bus_Be,
    input  logic        Bus_Gnt,
    input  logic        Bus_RValid,
    input  logic [31:0] Bus_RData
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic        bus_req_q,   bus_req_d;
    logic        we_q,        we_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [1:0]  lane_q,      lane_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [3:0]  be_q,        be_d;
    logic [31:0] read_data_q, read_data_d;
    logic        bus_err_q,   bus_err_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic        mem_op;
    logic        misaligned;
    logic        aligned_op;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [CNT_W-1:0] cnt_inc;

    assign mem_op  = Mem_Read_M | Mem_Write_M;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Alignment check on the presented op: halves need addr[0]=0, words addr[1:0]=0.
    always_comb begin
        misaligned = 1'b0;
        case (Funct3_M[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = Alu_Result_M[0];
            default: misaligned = (Alu_Result_M[1:0] != 2'b00);
        endcase
    end

    assign Misaligned_M = mem_op & misaligned;
    assign aligned_op   = mem_op & ~misaligned;

    // Byte enables and lane-replicated store data for the presented op.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = Write_Data_M;
        case (Funct3_M[1:0])
            2'b00: begin
                be_new    = 4'b0001 << Alu_Result_M[1:0];
                wdata_new = {4{Write_Data_M[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << Alu_Result_M[1:0];
                wdata_new = {2{Write_Data_M[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = Write_Data_M;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word using the captured offset.
    always_comb begin
        lane_byte = Bus_RData[7:0];
        case (lane_q)
            2'd0: lane_byte = Bus_RData[7:0];
            2'd1: lane_byte = Bus_RData[15:8];
            2'd2: lane_byte = Bus_RData[23:16];
            2'd3: lane_byte = Bus_RData[31:24];
            default: lane_byte = Bus_RData[7:0];
        endcase
        lane_half = lane_q[1] ? Bus_RData[31:16] : Bus_RData[15:0];
    end

    // Sign- or zero-extend the selected lane according to the captured funct3.
    always_comb begin
        load_ext = Bus_RData;
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_ext = {24'h000000, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_ext = {16'h0000, lane_half};
            default: load_ext = Bus_RData;
        endcase
    end

    // Transaction sequencer: next state, captured request fields, result and watchdog.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        read_data_d = read_data_q;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (aligned_op) begin
                    we_d      = Mem_Write_M;
                    funct3_d  = Funct3_M;
                    lane_d    = Alu_Result_M[1:0];
                    addr_d    = {Alu_Result_M[31:2], 2'b00};
                    wdata_d   = wdata_new;
                    be_d      = be_new;
                    cnt_d     = '0;
                    bus_req_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // A grant wins over a simultaneous timeout; RValid is not looked at here.
                if (Bus_Gnt) begin
                    bus_req_d = 1'b0;
                    state_d   = we_q ? S_DONE : S_WAIT;
                end else if (cnt_inc == CNT_LIMIT) begin
                    bus_req_d   = 1'b0;
                    bus_err_d   = 1'b1;
                    read_data_d = '0;
                    state_d     = S_DONE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (Bus_RValid) begin
                    read_data_d = load_ext;
                    state_d     = S_DONE;
                end else if (cnt_inc == CNT_LIMIT) begin
                    bus_err_d   = 1'b1;
                    read_data_d = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // The finished instruction is still presented here; let the pipeline move on.
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; an asynchronous reset abandons any transaction.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Stall_M    = ((state_q == S_IDLE) && aligned_op) ||
                        (state_q == S_REQ) || (state_q == S_WAIT);
    assign Read_DataM = read_data_q;
    assign Bus_Err_M  = bus_err_q;
    assign Bus_Req    = bus_req_q;
    assign Bus_We     = we_q;
    assign Bus_Addr   = addr_q;
    assign Bus_WData  = wdata_q;
    assign Bus_Be     = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed-vector bench for mem_stage_lsu. A default-timeout
// instance carries the functional scenarios; a second instance with a short
// timeout exercises the bus-error abort.
module tb_mem_stage_lsu;

    logic        Clk = 1'b0;
    logic        Reset;

    // Main instance
    logic        Mem_Read_M, Mem_Write_M;
    logic [2:0]  Funct3_M;
    logic [31:0] Alu_Result_M, Write_Data_M;
    logic [31:0] Read_DataM;
    logic        Stall_M, Misaligned_M, Bus_Err_M;
    logic        Bus_Req, Bus_We;
    logic [31:0] Bus_Addr, Bus_WData;
    logic [3:0]  Bus_Be;
    logic        Bus_Gnt, Bus_RValid;
    logic [31:0] Bus_RData;

    // Short-timeout instance
    logic        t_read, t_write;
    logic [2:0]  t_funct3;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] t_read_data;
    logic        t_stall, t_misaligned, t_err;
    logic        t_req, t_we;
    logic [31:0] t_bus_addr, t_bus_wdata;
    logic [3:0]  t_be;
    logic        t_gnt, t_rvalid;
    logic [31:0] t_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mem_stage_lsu dut (
        .Clk(Clk), .Reset(Reset),
        .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M), .Funct3_M(Funct3_M),
        .Alu_Result_M(Alu_Result_M), .Write_Data_M(Write_Data_M),
        .Read_DataM(Read_DataM), .Stall_M(Stall_M), .Misaligned_M(Misaligned_M),
        .Bus_Err_M(Bus_Err_M), .Bus_Req(Bus_Req), .Bus_We(Bus_We),
        .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData), .Bus_Be(Bus_Be),
        .Bus_Gnt(Bus_Gnt), .Bus_RValid(Bus_RValid), .Bus_RData(Bus_RData)
    );

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .Clk(Clk), .Reset(Reset),
        .Mem_Read_M(t_read), .Mem_Write_M(t_write), .Funct3_M(t_funct3),
        .Alu_Result_M(t_addr), .Write_Data_M(t_wdata),
        .Read_DataM(t_read_data), .Stall_M(t_stall), .Misaligned_M(t_misaligned),
        .Bus_Err_M(t_err), .Bus_Req(t_req), .Bus_We(t_we),
        .Bus_Addr(t_bus_addr), .Bus_WData(t_bus_wdata), .Bus_Be(t_be),
        .Bus_Gnt(t_gnt), .Bus_RValid(t_rvalid), .Bus_RData(t_rdata)
    );

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Drive one load on the main instance with scheduled Gnt/RValid cycles
    // (cycle 0 = presentation cycle) and report what came back.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                            input int gnt_at, input int rv_at,
                            input logic [31:0] rdata, input bit decoy,
                            output logic [31:0] rd, output int stall_cycles,
                            output int done_at, output logic [31:0] req_addr,
                            output logic [3:0] req_be);
        stall_cycles = 0;
        done_at      = -1;
        req_addr     = '0;
        req_be       = '0;
        rd           = Read_DataM;
        Mem_Read_M   = 1'b1;
        Funct3_M     = f3;
        Alu_Result_M = addr;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            Bus_Gnt    = (i == gnt_at);
            Bus_RValid = (i == rv_at) || (decoy && i == gnt_at);
            Bus_RData  = (i == rv_at) ? rdata : 32'h0BAD0BAD;
            #1;
            if (i == gnt_at) begin
                req_addr = Bus_Addr;
                req_be   = Bus_Be;
            end
            if (Stall_M) stall_cycles++;
            else if (i > 0) begin
                done_at = i;
                rd      = Read_DataM;
            end
            cyc();
        end
        Mem_Read_M = 1'b0;
        Bus_Gnt    = 1'b0;
        Bus_RValid = 1'b0;
        $display("load f3=%b addr=%h -> rd=%h stall=%0d done_at=%0d", f3, addr, rd, stall_cycles, done_at);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (Bus_Req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", Bus_Req); end
        n_cmp++; if (Bus_We !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", Bus_We); end
        n_cmp++; if (Bus_Addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", Bus_Addr); end
        n_cmp++; if (Bus_WData !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", Bus_WData); end
        n_cmp++; if (Bus_Be !== 4'h0) begin n_err++; $display("FAIL reset_be: got %b want 0000", Bus_Be); end
        n_cmp++; if (Read_DataM !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", Read_DataM); end
        n_cmp++; if (Bus_Err_M !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", Bus_Err_M); end
        n_cmp++; if (Stall_M !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", Stall_M); end
        Reset = 1'b0;
        cyc();
        $display("reset: req=%b be=%b rdata=%h stall=%b", Bus_Req, Bus_Be, Read_DataM, Stall_M);
    endtask

    task automatic test_reset_mid_wait();
        Mem_Read_M = 1'b1; Funct3_M = 3'b010; Alu_Result_M = 32'h300;
        #1;
        n_cmp++; if (Stall_M !== 1'b1) begin n_err++; $display("FAIL rmw_idle_stall: got %b want 1", Stall_M); end
        cyc();
        Bus_Gnt = 1'b1;
        #1;
        n_cmp++; if (Bus_Req !== 1'b1) begin n_err++; $display("FAIL rmw_req: got %b want 1", Bus_Req); end
        cyc();
        Bus_Gnt = 1'b0;
        #1;
        n_cmp++; if (Stall_M !== 1'b1) begin n_err++; $display("FAIL rmw_wait_stall: got %b want 1", Stall_M); end
        // Assert reset in the middle of WAIT, away from any clock edge.
        Reset = 1'b1; Mem_Read_M = 1'b0;
        #1;
        n_cmp++; if (Bus_Req !== 1'b0) begin n_err++; $display("FAIL rmw_reset_req: got %b want 0", Bus_Req); end
        n_cmp++; if (Stall_M !== 1'b0) begin n_err++; $display("FAIL rmw_reset_stall: got %b want 0", Stall_M); end
        cyc();
        Reset = 1'b0; Bus_RValid = 1'b1; Bus_RData = 32'hCAFEF00D;
        cyc();
        Bus_RValid = 1'b0;
        #1;
        n_cmp++; if (Read_DataM !== 32'h0) begin n_err++; $display("FAIL rmw_late_rvalid: got %h want 00000000", Read_DataM); end
        n_cmp++; if (Stall_M !== 1'b0) begin n_err++; $display("FAIL rmw_after_stall: got %b want 0", Stall_M); end
        cyc();
        $display("reset mid-wait: rdata=%h req=%b stall=%b", Read_DataM, Bus_Req, Stall_M);
    endtask

    task automatic test_store_word();
        int stall_cnt;
        stall_cnt = 0;
        Mem_Write_M = 1'b1; Funct3_M = 3'b010; Alu_Result_M = 32'h100; Write_Data_M = 32'hDEADBEEF;
        #1;
        if (Stall_M) stall_cnt++;
        n_cmp++; if (Bus_Req !== 1'b0) begin n_err++; $display("FAIL sw_req_early: got %b want 0", Bus_Req); end
        cyc();
        Bus_Gnt = 1'b1;
        #1;
        if (Stall_M) stall_cnt++;
        n_cmp++; if (Bus_Req !== 1'b1) begin n_err++; $display("FAIL sw_req: got %b want 1", Bus_Req); end
        n_cmp++; if (Bus_Addr !== 32'h100) begin n_err++; $display("FAIL sw_addr: got %h want 00000100", Bus_Addr); end
        n_cmp++; if (Bus_Be !== 4'b1111) begin n_err++; $display("FAIL sw_be: got %b want 1111", Bus_Be); end
        n_cmp++; if (Bus_We !== 1'b1) begin n_err++; $display("FAIL sw_we: got %b want 1", Bus_We); end
        n_cmp++; if (Bus_WData !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_wdata: got %h want deadbeef", Bus_WData); end
        cyc();
        Bus_Gnt = 1'b0;
        #1;
        if (Stall_M) stall_cnt++;
        n_cmp++; if (Bus_Req !== 1'b0) begin n_err++; $display("FAIL sw_done_req: got %b want 0", Bus_Req); end
        cyc();
        Mem_Write_M = 1'b0;
        #1;
        if (Stall_M) stall_cnt++;
        n_cmp++; if (stall_cnt !== 2) begin n_err++; $display("FAIL sw_stall_cycles: got %0d want 2", stall_cnt); end
        $display("store word: stall_cycles=%0d", stall_cnt);
    endtask

    task automatic test_back_to_back();
        Mem_Write_M = 1'b1; Funct3_M = 3'b000; Alu_Result_M = 32'h103; Write_Data_M = 32'h12345678;
        #1;
        n_cmp++; if (Stall_M !== 1'b1) begin n_err++; $display("FAIL sb_stall: got %b want 1", Stall_M); end
        cyc();
        Bus_Gnt = 1'b1;
        #1;
        n_cmp++; if (Bus_Addr !== 32'h100) begin n_err++; $display("FAIL sb_addr: got %h want 00000100", Bus_Addr); end
        n_cmp++; if (Bus_Be !== 4'b1000) begin n_err++; $display("FAIL sb_be: got %b want 1000", Bus_Be); end
        n_cmp++; if (Bus_WData !== 32'h78787878) begin n_err++; $display("FAIL sb_wdata: got %h want 78787878", Bus_WData); end
        cyc();
        Bus_Gnt = 1'b0;
        #1;
        n_cmp++; if (Stall_M !== 1'b0) begin n_err++; $display("FAIL sb_done_stall: got %b want 0", Stall_M); end
        cyc();
        // Second store presented in the cycle right after DONE.
        Funct3_M = 3'b001; Alu_Result_M = 32'h106; Write_Data_M = 32'h0000ABCD;
        #1;
        n_cmp++; if (Stall_M !== 1'b1) begin n_err++; $display("FAIL b2b_idle_stall: got %b want 1", Stall_M); end
        cyc();
        Bus_Gnt = 1'b1;
        #1;
        n_cmp++; if (Bus_Req !== 1'b1) begin n_err++; $display("FAIL sh_req: got %b want 1", Bus_Req); end
        n_cmp++; if (Bus_Addr !== 32'h104) begin n_err++; $display("FAIL sh_addr: got %h want 00000104", Bus_Addr); end
        n_cmp++; if (Bus_Be !== 4'b1100) begin n_err++; $display("FAIL sh_be: got %b want 1100", Bus_Be); end
        n_cmp++; if (Bus_WData !== 32'hABCDABCD) begin n_err++; $display("FAIL sh_wdata: got %h want abcdabcd", Bus_WData); end
        cyc();
        Bus_Gnt = 1'b0;
        #1;
        n_cmp++; if (Stall_M !== 1'b0) begin n_err++; $display("FAIL sh_done_stall: got %b want 0", Stall_M); end
        cyc();
        Mem_Write_M = 1'b0;
        #1;
        $display("back-to-back SB/SH done");
    endtask

    task automatic test_load_byte();
        logic [31:0] rd, ra;
        logic [3:0]  rb;
        int st, dn;
        run_load(3'b000, 32'h102, 3, 6, 32'h0080FF00, 1'b0, rd, st, dn, ra, rb);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_data: got %h want ffffff80", rd); end
        n_cmp++; if (st !== 7) begin n_err++; $display("FAIL lb_stall_cycles: got %0d want 7", st); end
        n_cmp++; if (dn !== 7) begin n_err++; $display("FAIL lb_done_cycle: got %0d want 7", dn); end
        n_cmp++; if (ra !== 32'h100) begin n_err++; $display("FAIL lb_addr: got %h want 00000100", ra); end
        n_cmp++; if (rb !== 4'b0100) begin n_err++; $display("FAIL lb_be: got %b want 0100", rb); end
        // An intervening store must leave the load result alone.
        Mem_Write_M = 1'b1; Funct3_M = 3'b010; Alu_Result_M = 32'h180; Write_Data_M = 32'h11111111;
        cyc();
        Bus_Gnt = 1'b1;
        cyc();
        Bus_Gnt = 1'b0;
        cyc();
        Mem_Write_M = 1'b0;
        #1;
        n_cmp++; if (Read_DataM !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_hold: got %h want ffffff80", Read_DataM); end
        run_load(3'b100, 32'h102, 1, 2, 32'h0080FF00, 1'b0, rd, st, dn, ra, rb);
        n_cmp++; if (rd !== 32'h00000080) begin n_err++; $display("FAIL lbu_data: got %h want 00000080", rd); end
        n_cmp++; if (dn !== 3) begin n_err++; $display("FAIL lbu_done_cycle: got %0d want 3", dn); end
    endtask

    task automatic test_load_half_word();
        logic [31:0] rd, ra;
        logic [3:0]  rb;
        int st, dn;
        // RValid alongside Gnt in REQ carries decoy data that must be ignored.
        run_load(3'b001, 32'h102, 1, 3, 32'h80010000, 1'b1, rd, st, dn, ra, rb);
        n_cmp++; if (rd !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_data: got %h want ffff8001", rd); end
        n_cmp++; if (dn !== 4) begin n_err++; $display("FAIL lh_done_cycle: got %0d want 4", dn); end
        n_cmp++; if (rb !== 4'b1100) begin n_err++; $display("FAIL lh_be: got %b want 1100", rb); end
        run_load(3'b101, 32'h100, 1, 2, 32'h1234F00D, 1'b0, rd, st, dn, ra, rb);
        n_cmp++; if (rd !== 32'h0000F00D) begin n_err++; $display("FAIL lhu_data: got %h want 0000f00d", rd); end
        run_load(3'b010, 32'h104, 1, 2, 32'h89ABCDEF, 1'b0, rd, st, dn, ra, rb);
        n_cmp++; if (rd !== 32'h89ABCDEF) begin n_err++; $display("FAIL lw_data: got %h want 89abcdef", rd); end
        n_cmp++; if (ra !== 32'h104) begin n_err++; $display("FAIL lw_addr: got %h want 00000104", ra); end
        n_cmp++; if (rb !== 4'b1111) begin n_err++; $display("FAIL lw_be: got %b want 1111", rb); end
    endtask

    task automatic test_misaligned();
        int req_seen, stall_seen;
        req_seen = 0; stall_seen = 0;
        Mem_Read_M = 1'b1; Funct3_M = 3'b010; Alu_Result_M = 32'h102;
        #1;
        n_cmp++; if (Misaligned_M !== 1'b1) begin n_err++; $display("FAIL lw_mis_flag: got %b want 1", Misaligned_M); end
        for (int i = 0; i < 4; i++) begin
            if (Bus_Req) req_seen++;
            if (Stall_M) stall_seen++;
            cyc();
            #1;
        end
        n_cmp++; if (req_seen !== 0) begin n_err++; $display("FAIL lw_mis_req: got %0d req cycles want 0", req_seen); end
        n_cmp++; if (stall_seen !== 0) begin n_err++; $display("FAIL lw_mis_stall: got %0d stall cycles want 0", stall_seen); end
        n_cmp++; if (Read_DataM !== 32'h89ABCDEF) begin n_err++; $display("FAIL lw_mis_hold: got %h want 89abcdef", Read_DataM); end
        Mem_Read_M = 1'b0; Mem_Write_M = 1'b1; Funct3_M = 3'b001; Alu_Result_M = 32'h101;
        #1;
        n_cmp++; if (Misaligned_M !== 1'b1) begin n_err++; $display("FAIL sh_mis_flag: got %b want 1", Misaligned_M); end
        Mem_Write_M = 1'b0; Mem_Read_M = 1'b1; Alu_Result_M = 32'h102;
        #1;
        n_cmp++; if (Misaligned_M !== 1'b0) begin n_err++; $display("FAIL lh_aligned_flag: got %b want 0", Misaligned_M); end
        n_cmp++; if (Stall_M !== 1'b1) begin n_err++; $display("FAIL lh_aligned_stall: got %b want 1", Stall_M); end
        Mem_Read_M = 1'b0;
        cyc();
        #1;
        n_cmp++; if (Bus_Req !== 1'b0) begin n_err++; $display("FAIL mis_after_req: got %b want 0", Bus_Req); end
        $display("misaligned: req_cycles=%0d stall_cycles=%0d", req_seen, stall_seen);
    endtask

    task automatic test_timeout();
        int err_cnt, req_cnt, err_at;
        // A successful load first, so the abort's zeroing of the result is visible.
        t_read = 1'b1; t_funct3 = 3'b010; t_addr = 32'h204;
        cyc();
        t_gnt = 1'b1;
        cyc();
        t_gnt = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h13579BDF;
        cyc();
        t_rvalid = 1'b0;
        #1;
        n_cmp++; if (t_read_data !== 32'h13579BDF) begin n_err++; $display("FAIL to_pre_load: got %h want 13579bdf", t_read_data); end
        cyc();
        t_addr = 32'h208;
        err_cnt = 0; req_cnt = 0; err_at = -1;
        for (int i = 0; i < 9; i++) begin
            t_read = (i < 6);
            #1;
            if (t_req) req_cnt++;
            if (t_err) begin err_cnt++; err_at = i; end
            if (i == 5) begin
                n_cmp++; if (t_read_data !== 32'h0) begin n_err++; $display("FAIL to_rdata: got %h want 00000000", t_read_data); end
                n_cmp++; if (t_req !== 1'b0) begin n_err++; $display("FAIL to_req_drop: got %b want 0", t_req); end
            end
            if (i == 6) begin
                n_cmp++; if (t_stall !== 1'b0) begin n_err++; $display("FAIL to_idle_stall: got %b want 0", t_stall); end
            end
            cyc();
        end
        n_cmp++; if (err_cnt !== 1) begin n_err++; $display("FAIL to_err_pulses: got %0d want 1", err_cnt); end
        n_cmp++; if (err_at !== 5) begin n_err++; $display("FAIL to_err_cycle: got %0d want 5", err_at); end
        n_cmp++; if (req_cnt !== 4) begin n_err++; $display("FAIL to_req_cycles: got %0d want 4", req_cnt); end
        $display("timeout: err_pulses=%0d at=%0d req_cycles=%0d", err_cnt, err_at, req_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Mem_Read_M = 1'b0; Mem_Write_M = 1'b0; Funct3_M = 3'b000;
        Alu_Result_M = '0; Write_Data_M = '0;
        Bus_Gnt = 1'b0; Bus_RValid = 1'b0; Bus_RData = '0;
        t_read = 1'b0; t_write = 1'b0; t_funct3 = 3'b000;
        t_addr = '0; t_wdata = '0; t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata = '0;
        repeat (3) @(posedge Clk);
        #1;
        test_reset();
        test_reset_mid_wait();
        test_store_word();
        test_back_to_back();
        test_load_byte();
        test_load_half_word();
        test_misaligned();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit for the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the ALU address, store data and memory control of the instruction in the memory stage, and runs a request/grant/response transaction on the data-memory bus. It returns sign- or zero-extended load data as Read_DataM and raises Stall_M to freeze upstream stages while a transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, max cycles in REQ+WAIT before the bus error abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- Mem_Read_M  in  1  load in memory stage
- Mem_Write_M  in  1  store in memory stage; Mem_Read_M and Mem_Write_M are never both 1
- Funct3_M  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- Alu_Result_M  in  32  effective byte address
- Write_Data_M  in  32  store data, right-aligned
- Read_DataM  out  32  extended load data, to MEM/WB register
- Stall_M  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- Misaligned_M  out  1  misaligned access flag, combinational
- Bus_Err_M  out  1  one-cycle pulse on timeout abort
- Bus_Req  out  1  request valid
- Bus_We  out  1  1 = write
- Bus_Addr  out  32  word address, bits [1:0] = 0
- Bus_WData  out  32  lane-shifted store data
- Bus_Be  out  4  byte enables
- Bus_Gnt  in  1  request accepted this cycle
- Bus_RValid  in  1  read data valid
- Bus_RData  in  32  read word

## Operation
- Alignment rule: a half access with addr[0]=1 is misaligned; a word access with addr[1:0]≠0 is misaligned.
- Misaligned access:
  - Misaligned_M=1 in the same cycle.
  - No bus transaction and no stall.
  - Read_DataM is held.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On an aligned memory op, capture into internal registers: we, funct3, addr[1:0], Bus_Addr, Bus_WData, Bus_Be.
  - Clear the timeout counter and go to REQ.
  - Non-memory op: stay in IDLE.
- REQ: Bus_Req=1, fields stable.
  - On Bus_Gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on Bus_RValid, extract the lane using the captured addr[1:0], extend per the captured funct3, register into Read_DataM, then go to DONE.
  - Bus_RValid is ignored outside WAIT.
- DONE: one cycle, Stall_M=0, inputs ignored (the same instruction is still presented), then go to IDLE.
- Stall_M = (IDLE and aligned memory op) or REQ or WAIT.
- Store lanes:
  - SB: Be=0001<<addr[1:0], data replicated on all four bytes.
  - SH: Be=0011<<addr[1:0], data replicated on both halves.
  - SW: Be=1111.
- Load Be: same pattern as stores (informational).
- Timeout:
  - The counter increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES: Bus_Err_M pulses, Read_DataM=0, go to DONE, Bus_Req drops.
- Reset mid-transaction: async return to IDLE. Any later Gnt/RValid for the aborted op is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - Read_DataM, Bus_Addr, Bus_WData = 0.
  - Bus_Be = 0; Bus_Req, Bus_We = 0.
  - Bus_Err_M = 0, counter = 0.
- Bus_Req is registered: it first rises the cycle after the op is presented.
- Latency with Gnt in the first REQ cycle:
  - Store: IDLE(T) → REQ(T+1) → DONE(T+2). Stall_M high at T and T+1.
  - Load with RValid k cycles after Gnt: DONE at T+2+k. Read_DataM is valid from DONE onward and is held until the next load completes.
- Back-to-back memory ops: the second op's IDLE cycle is the cycle after DONE (minimum 3 cycles per store).
- Gnt and RValid both high in REQ: only Gnt is honoured.

## Test plan
- Reset asserted mid-WAIT, then RValid=1 after release:
  - Expect Bus_Req=0, Stall_M=0 immediately.
  - Expect no change to Read_DataM.
- SW 0xDEADBEEF to 0x100, Gnt immediate:
  - Expect Bus_Addr=0x100, Be=1111, We=1, WData=0xDEADBEEF.
  - Expect Stall_M high 2 cycles.
- SB 0x12345678 to 0x103:
  - Expect Addr=0x100, Be=1000, WData=0x78787878.
- LB from 0x102 with RData=0x0080FF00, Gnt delayed 2 cycles, RValid 3 cycles after Gnt:
  - Expect Read_DataM=0xFFFFFF80 in DONE.
  - Expect Stall_M high exactly 7 cycles.
  - LBU to the same address: expect 0x00000080.
- LW to 0x102:
  - Expect Misaligned_M=1, Bus_Req never set, Stall_M=0.
- TIMEOUT_CYCLES=4, LW with Gnt never asserted:
  - Expect Bus_Err_M to pulse once after 4 REQ cycles, Read_DataM=0.
  - Expect return to IDLE one cycle later.
